tinker_fetch: RTL and testbench
===============================

Name: tinker_fetch

Overview:
- Instruction-fetch stage directly upstream of the Tinker core's decode/register/ALU datapath; it supplies the 32-bit `instruction` word that the core consumes.
- Holds the fetch PC and issues in-order word requests to instruction memory over a valid/ready request and valid-only response interface.
- Buffers returned words in a small FIFO and presents them to decode with valid/ready.
- Accepts branch/jump redirects from the core, flushes the buffer and discards stale in-flight responses.

Parameters:
- RESET_PC, 64'h2000, fetch address loaded on reset (Tinker program start).
- MEM_SIZE, 524288, instruction memory size in bytes; fetch addresses must be < MEM_SIZE.
- FIFO_DEPTH, 2, instruction buffer entries; also the maximum outstanding plus buffered words.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  redirect fetch to redirect_pc this cycle
- redirect_pc  in  64  new fetch address
- mem_req_valid  out  1  request pending
- mem_req_addr  out  64  byte address of requested word
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  response word valid; responses return in request order, latency ≥1
- mem_resp_data  in  32  instruction word
- inst_valid  out  1  instruction/inst_pc valid to decode
- instruction  out  32  FIFO head word
- inst_pc  out  64  byte address of FIFO head word
- inst_ready  in  1  decode consumes head
- fetch_fault  out  1  sticky fault indication

Behaviour:
- Reset (sampled high on an edge):
  - fetch_pc and resp_pc load RESET_PC; FIFO empties.
  - outstanding and drop counters clear; state becomes RUN.
  - Outputs during and after reset: mem_req_valid=0 while reset is high, inst_valid=0, instruction=0, inst_pc=RESET_PC, fetch_fault=0.
  - Reset mid-operation abandons all state; later responses for pre-reset requests are not tracked, so memory must be quiesced with the core.
- States: RUN, FAULT.
- Requests:
  - mem_req_addr = fetch_pc.
  - mem_req_valid = (state==RUN) && !reset && (outstanding + fifo_count < FIFO_DEPTH).
  - On mem_req_valid && mem_req_ready: outstanding += 1 and fetch_pc += 4.
  - If the new fetch_pc > MEM_SIZE-4, go to FAULT.
  - First request is presented in the first cycle with reset low.
- Responses:
  - On mem_resp_valid with drop_count > 0: discard the word, drop_count -= 1, outstanding -= 1.
  - Otherwise: push {mem_resp_data, resp_pc} into the FIFO, resp_pc += 4, outstanding -= 1.
  - A word is visible on inst_valid the cycle after its response (no bypass). Minimum request-to-inst_valid latency is 2 cycles with 1-cycle memory.
  - Credit rule guarantees the FIFO never overflows. A response with outstanding==0 is a protocol error; it is ignored.
- Decode handshake:
  - inst_valid = fifo_count != 0; pop on inst_valid && inst_ready.
  - instruction and inst_pc hold stable while inst_valid && !inst_ready.
  - When the FIFO is empty, instruction and inst_pc hold their last values.
- Redirect (highest priority, applies in the cycle redirect_valid is high):
  - fetch_pc and resp_pc load redirect_pc; the FIFO flushes.
  - drop_count = outstanding after this cycle's request and response accounting. A same-cycle request handshake is stale; a same-cycle response is dropped.
  - A same-cycle inst_valid && inst_ready pop still counts as delivered.
  - mem_req_valid may change address or deassert in a redirect cycle without a handshake; the first request at redirect_pc appears no earlier than the next cycle.
  - If redirect_pc[1:0] != 0 or redirect_pc > MEM_SIZE-4, enter FAULT instead.
  - A redirect in FAULT is ignored.
- FAULT:
  - No new requests; fetch_fault=1 until reset.
  - Outstanding responses are still absorbed: pushed if not stale, so instructions already in flight drain to decode.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, decode always ready → requests at 0x2000, 0x2004, 0x2008…; inst_pc sequence matches; inst_valid first high 2 cycles after reset drops.
- inst_ready=0 for 5 cycles → exactly FIFO_DEPTH requests issued, then mem_req_valid=0; instruction/inst_pc stable; resumes one request per pop.
- Redirect to 0x3000 while 2 responses outstanding → both responses dropped; next inst_pc=0x3000, next request address 0x3000.
- Redirect in the same cycle as a response and a request handshake → response discarded, the stale request's response also discarded; inst_valid only for 0x3000.
- Redirect to 0x3002 → fetch_fault=1, no further requests, stays high until reset; reset restores fetch from 0x2000.
- Sequential fetch up to MEM_SIZE-4 (0x7FFFC) → that word is delivered, then FAULT with no request beyond 0x7FFFC.

Source files
------------

// File: rtl/tinker_fetch.sv
// -----------------------------------------------------------------------------
// tinker_fetch
//
// Instruction-fetch stage feeding the Tinker core's decode stage. It holds the
// fetch PC and issues in-order word requests to instruction memory. Returned
// words go into a small FIFO and are presented to decode with valid/ready.
// Branch/jump redirects from the core flush the buffer, and the responses that
// are still in flight for the old path are counted and discarded.
//
// Credit scheme: a request is issued only while (words in flight + words
// buffered) < FIFO_DEPTH. Every response therefore has a free FIFO slot, so
// the buffer never overflows and memory never needs to be back-pressured.
//
// Ports
//   clk             in   1   clock; all state updates on the rising edge
//   reset           in   1   synchronous, active-high
//   redirect_valid  in   1   redirect fetch to redirect_pc this cycle
//   redirect_pc     in  64   new fetch byte address
//   mem_req_valid   out  1   request pending
//   mem_req_addr    out 64   byte address of the requested word
//   mem_req_ready   in   1   memory accepts the request
//   mem_resp_valid  in   1   response word valid (in request order, latency >= 1)
//   mem_resp_data   in  32   returned instruction word
//   inst_valid      out  1   instruction / inst_pc valid to decode
//   instruction     out 32   FIFO head word (last head held while empty)
//   inst_pc         out 64   byte address of the FIFO head word
//   inst_ready      in   1   decode consumes the head
//   fetch_fault     out  1   sticky fault; cleared only by reset
// -----------------------------------------------------------------------------
module tinker_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h2000,
    parameter logic [63:0] MEM_SIZE   = 64'd524288,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_fault
);

    // Counters must hold the value FIFO_DEPTH itself (all credits in use).
    localparam int              CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int              PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [63:0]     LAST_ADDR = MEM_SIZE - 64'd4;
    localparam logic [CNT_W:0]  CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [63:0] pc;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state,       state_n;
    logic [63:0]      fetch_pc,    fetch_pc_n;    // address of the next request
    logic [63:0]      resp_pc,     resp_pc_n;     // address of the next kept response
    logic [CNT_W-1:0] outstanding, outstanding_n; // requests accepted, response not yet seen
    logic [CNT_W-1:0] drop_count,  drop_count_n;  // in-flight responses from a dead path
    logic [CNT_W-1:0] fifo_count,  fifo_count_n;
    logic [PTR_W-1:0] wr_ptr,      wr_ptr_n;
    logic [PTR_W-1:0] rd_ptr,      rd_ptr_n;
    logic [31:0]      last_word,   last_word_n;   // head shown most recently
    logic [63:0]      last_pc,     last_pc_n;

    entry_t           fifo_mem [FIFO_DEPTH];
    entry_t           head;

    // -------------------------------------------------------------------------
    // Per-cycle events
    // -------------------------------------------------------------------------
    logic             req_fire;
    logic             resp_take;
    logic             resp_drop;
    logic             push;
    logic             pop;
    logic             redirect_take;
    logic             redirect_bad;
    logic             redirect_ok;
    logic [63:0]      fetch_pc_inc;
    logic [CNT_W:0]   credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign head         = fifo_mem[rd_ptr];
    assign fetch_pc_inc = fetch_pc + 64'd4;
    assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};

    // Requests never stall on anything but credits, so the address is simply
    // the fetch PC; it may change without a handshake in a redirect cycle.
    assign mem_req_addr  = fetch_pc;
    assign mem_req_valid = (state == ST_RUN) && !reset && (credit_used < CREDITS);
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_take = mem_resp_valid && (outstanding != '0);
    assign resp_drop = resp_take && (drop_count != '0);

    assign inst_valid  = (fifo_count != '0);
    assign pop         = inst_valid && inst_ready;
    assign instruction = inst_valid ? head.word : last_word;
    assign inst_pc     = inst_valid ? head.pc   : last_pc;
    assign fetch_fault = (state == ST_FAULT);

    // Redirects are ignored once faulted; a bad target faults instead of
    // redirecting, leaving the current path's in-flight words to drain.
    assign redirect_take = redirect_valid && (state == ST_RUN);
    assign redirect_bad  = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_ADDR);
    assign redirect_ok   = redirect_take && !redirect_bad;

    // A good redirect flushes the buffer, so a same-cycle live response is
    // discarded rather than written.
    assign push = resp_take && !resp_drop && !redirect_ok;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through this block leaves one unassigned and infers a latch.
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        resp_pc_n     = resp_pc;
        outstanding_n = outstanding;
        drop_count_n  = drop_count;
        fifo_count_n  = fifo_count;
        wr_ptr_n      = wr_ptr;
        rd_ptr_n      = rd_ptr;
        last_word_n   = last_word;
        last_pc_n     = last_pc;

        // Track the visible head so the outputs hold it once the FIFO empties.
        if (inst_valid) begin
            last_word_n = head.word;
            last_pc_n   = head.pc;
        end

        outstanding_n = outstanding + CNT_W'(req_fire) - CNT_W'(resp_take);

        if (req_fire) begin
            fetch_pc_n = fetch_pc_inc;
            // Stop before the next word would fall outside instruction memory.
            if (fetch_pc_inc > LAST_ADDR) begin
                state_n = ST_FAULT;
            end
        end

        if (resp_drop) begin
            drop_count_n = drop_count - CNT_W'(1);
        end

        if (push) begin
            resp_pc_n = resp_pc + 64'd4;
            wr_ptr_n  = ptr_inc(wr_ptr);
        end

        if (pop) begin
            rd_ptr_n = ptr_inc(rd_ptr);
        end

        fifo_count_n = fifo_count + CNT_W'(push) - CNT_W'(pop);

        // Redirect has the last word. Everything still in flight after this
        // cycle's accounting, including a request accepted this very cycle,
        // belongs to the old path and must be discarded on return.
        if (redirect_take) begin
            if (redirect_bad) begin
                state_n = ST_FAULT;
            end else begin
                state_n      = ST_RUN;
                fetch_pc_n   = redirect_pc;
                resp_pc_n    = redirect_pc;
                drop_count_n = outstanding_n;
                fifo_count_n = '0;
                wr_ptr_n     = '0;
                rd_ptr_n     = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_count  <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_word   <= '0;
            last_pc     <= RESET_PC;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            resp_pc     <= resp_pc_n;
            outstanding <= outstanding_n;
            drop_count  <= drop_count_n;
            fifo_count  <= fifo_count_n;
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            last_word   <= last_word_n;
            last_pc     <= last_pc_n;
        end
    end

    // -------------------------------------------------------------------------
    // Instruction buffer storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; fifo_count alone says
    // which entries are meaningful, and empty-FIFO outputs come from last_*.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{word: mem_resp_data, pc: resp_pc};
        end
    end

endmodule

// File: tb/tb_tinker_fetch.sv
// -----------------------------------------------------------------------------
// tb_tinker_fetch
//
// Self-checking bench for tinker_fetch. A behavioural memory returns
// mem_word(addr) in request order after a configurable latency. A queue-level
// reference model tracks the words in flight (each tagged live or stale and
// carrying the PC it should deliver as) and the words buffered for decode;
// every cycle the DUT outputs are compared with what that model predicts.
// A directed vector table covers the reset-release pipeline timing, and
// hand-written sequences cover stall, redirect and fault corner cases before
// a randomized run.
// -----------------------------------------------------------------------------
module tb_tinker_fetch;

    localparam logic [63:0] RESET_PC = 64'h2000;
    localparam logic [63:0] MEM_SIZE = 64'd524288;
    localparam int          DEPTH    = 2;
    localparam logic [63:0] LAST     = MEM_SIZE - 64'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;

    always #5 clk = ~clk;

    tinker_fetch #(
        .RESET_PC   (RESET_PC),
        .MEM_SIZE   (MEM_SIZE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_fault    (fetch_fault)
    );

    // ------------------------------------------------------------------ model
    typedef struct {
        logic [63:0] addr;  // address memory actually received
        logic [63:0] pc;    // address the word should be delivered as
        bit          live;
        int          due;
    } req_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } word_t;

    req_t        pend[$];
    word_t       buffered[$];
    logic [63:0] m_fetch;
    bit          m_fault;
    logic [31:0] m_last_word;
    logic [63:0] m_last_pc;
    int          cycle;
    int          last_due;
    int          lat_min;
    int          lat_max;

    // drive values applied by step()
    bit          d_reset;
    bit          d_req_ready;
    bit          d_inst_ready;
    bit          d_redirect;
    logic [63:0] d_redirect_pc;

    // values sampled by step()
    bit          s_req_valid;
    logic [63:0] s_req_addr;
    bit          s_inst_valid;
    logic [63:0] s_inst_pc;
    logic [31:0] s_inst;
    bit          s_fault;
    bit          s_hs;
    bit          s_pop;
    bit          s_resp;

    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, sample and compare
    // just after, then advance the model by what the next rising edge does.
    task automatic step();
        req_t        r;
        int          due;
        bit          fault_before;
        bit          good;
        bit          bad;
        bit          exp_req_valid;
        logic [31:0] exp_word;
        logic [63:0] exp_pc;

        @(negedge clk);
        reset          = d_reset;
        mem_req_ready  = d_req_ready;
        inst_ready     = d_inst_ready;
        redirect_valid = d_redirect;
        redirect_pc    = d_redirect_pc;
        s_resp         = !d_reset && (pend.size() != 0) && (pend[0].due <= cycle);
        mem_resp_valid = s_resp;
        mem_resp_data  = s_resp ? mem_word(pend[0].addr) : $urandom();
        #1;
        s_req_valid  = mem_req_valid;
        s_req_addr   = mem_req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_inst       = instruction;
        s_fault      = fetch_fault;

        if (d_reset) begin
            check("req_valid_in_reset", 64'(mem_req_valid), 64'd0);
            s_hs  = 1'b0;
            s_pop = 1'b0;
            pend.delete();
            buffered.delete();
            m_fetch     = RESET_PC;
            m_fault     = 1'b0;
            m_last_word = 32'h0;
            m_last_pc   = RESET_PC;
            last_due    = cycle;
        end else begin
            exp_req_valid = !m_fault && ((pend.size() + buffered.size()) < DEPTH);
            if (buffered.size() != 0) begin
                exp_pc   = buffered[0].pc;
                exp_word = buffered[0].word;
            end else begin
                exp_pc   = m_last_pc;
                exp_word = m_last_word;
            end
            check("req_valid",   64'(mem_req_valid), 64'(exp_req_valid));
            if (exp_req_valid) check("req_addr", mem_req_addr, m_fetch);
            check("inst_valid",  64'(inst_valid), 64'(buffered.size() != 0));
            check("inst_pc",     inst_pc, exp_pc);
            check("instruction", 64'(instruction), 64'(exp_word));
            check("fetch_fault", 64'(fetch_fault), 64'(m_fault));

            fault_before = m_fault;
            s_hs  = mem_req_valid && d_req_ready;
            s_pop = inst_valid && d_inst_ready;
            good  = d_redirect && !fault_before && (d_redirect_pc[1:0] == 2'b00) &&
                    (d_redirect_pc <= LAST);
            bad   = d_redirect && !fault_before && !good;

            if (buffered.size() != 0) begin
                m_last_pc   = buffered[0].pc;
                m_last_word = buffered[0].word;
                if (s_pop) void'(buffered.pop_front());
            end

            if (s_resp) begin
                r = pend.pop_front();
                if (r.live && !good) buffered.push_back('{pc: r.pc, word: mem_word(r.pc)});
            end

            if (s_hs) begin
                due = cycle + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: mem_req_addr, pc: m_fetch, live: 1'b1, due: due});
                m_fetch = m_fetch + 64'd4;
                if (m_fetch > LAST) m_fault = 1'b1;
            end

            if (good) begin
                foreach (pend[i]) pend[i].live = 1'b0;
                buffered.delete();
                m_fetch = d_redirect_pc;
                m_fault = 1'b0;
            end else if (bad) begin
                m_fault = 1'b1;
            end
        end
        cycle++;
    endtask

    task automatic do_reset();
        d_reset    = 1'b1;
        d_redirect = 1'b0;
        step();
        step();
        d_reset = 1'b0;
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct {
        bit          req_ready;
        bit          inst_ready;
        bit          exp_req_valid;
        logic [63:0] exp_addr;
        bit          exp_inst_valid;
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          hs_count;
        bit          got_req;
        bit          got_inst;
        logic [63:0] first_req;
        logic [63:0] first_pc;
        logic [63:0] max_addr;
        logic [63:0] last_pop_pc;
        int          fault_cycles;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        inst_ready     = 1'b0;
        cycle          = 0;
        last_due       = 0;
        lat_min        = 1;
        lat_max        = 1;
        d_req_ready    = 1'b1;
        d_inst_ready   = 1'b1;
        d_redirect     = 1'b0;
        d_redirect_pc  = 64'h0;

        // Reset release, 1-cycle memory, everything ready: two requests, a
        // credit bubble, then a steady 2-of-3 cadence; first word on cycle 2.
        vecs[0] = '{1, 1, 1, 64'h2000, 0, 64'h2000, 32'h0};
        vecs[1] = '{1, 1, 1, 64'h2004, 0, 64'h2000, 32'h0};
        vecs[2] = '{1, 1, 0, 64'h2008, 1, 64'h2000, mem_word(64'h2000)};
        vecs[3] = '{1, 1, 1, 64'h2008, 1, 64'h2004, mem_word(64'h2004)};
        vecs[4] = '{1, 1, 1, 64'h200C, 0, 64'h2004, mem_word(64'h2004)};
        vecs[5] = '{1, 1, 0, 64'h2010, 1, 64'h2008, mem_word(64'h2008)};
        vecs[6] = '{1, 1, 1, 64'h2010, 1, 64'h200C, mem_word(64'h200C)};
        vecs[7] = '{1, 1, 1, 64'h2014, 0, 64'h200C, mem_word(64'h200C)};
        vecs[8] = '{1, 1, 0, 64'h2018, 1, 64'h2010, mem_word(64'h2010)};
        vecs[9] = '{1, 1, 1, 64'h2018, 1, 64'h2014, mem_word(64'h2014)};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            d_req_ready  = vecs[i].req_ready;
            d_inst_ready = vecs[i].inst_ready;
            step();
            check($sformatf("vec%0d_req_valid", i),  64'(s_req_valid), 64'(vecs[i].exp_req_valid));
            check($sformatf("vec%0d_req_addr", i),   s_req_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_inst_valid", i), 64'(s_inst_valid), 64'(vecs[i].exp_inst_valid));
            check($sformatf("vec%0d_inst_pc", i),    s_inst_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_inst", i),       64'(s_inst), 64'(vecs[i].exp_inst));
            if (i == 0) check("vec0_fault", 64'(s_fault), 64'd0);
        end

        // Decode stalled: exactly DEPTH requests, head held, then one request per pop.
        do_reset();
        d_inst_ready = 1'b0;
        hs_count = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_hs) hs_count++;
        end
        check("stall_req_count", 64'(hs_count), 64'(DEPTH));
        check("stall_req_valid", 64'(s_req_valid), 64'd0);
        check("stall_inst_pc",   s_inst_pc, 64'h2000);
        check("stall_inst",      64'(s_inst), 64'(mem_word(64'h2000)));
        d_inst_ready = 1'b1;
        step();
        check("stall_pop",       64'(s_pop), 64'd1);
        step();
        check("resume_req_valid", 64'(s_req_valid), 64'd1);
        check("resume_req_addr",  s_req_addr, 64'h2008);
        for (int i = 0; i < 6; i++) step();

        // Redirect while two responses are outstanding (3-cycle memory).
        lat_min = 3;
        lat_max = 3;
        do_reset();
        step();
        step();
        d_redirect    = 1'b1;
        d_redirect_pc = 64'h3000;
        step();
        check("t3_credit_full", 64'(s_req_valid), 64'd0);
        d_redirect = 1'b0;
        got_req  = 1'b0;
        got_inst = 1'b0;
        first_req = 64'h0;
        first_pc  = 64'h0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_hs && !got_req) begin
                got_req   = 1'b1;
                first_req = s_req_addr;
            end
            if (s_inst_valid && !got_inst) begin
                got_inst = 1'b1;
                first_pc = s_inst_pc;
            end
        end
        check("t3_got_req",   64'(got_req), 64'd1);
        check("t3_first_req", first_req, 64'h3000);
        check("t3_got_inst",  64'(got_inst), 64'd1);
        check("t3_first_pc",  first_pc, 64'h3000);

        // Redirect in the same cycle as a response and a request handshake.
        lat_min = 1;
        lat_max = 1;
        do_reset();
        step();
        d_redirect    = 1'b1;
        d_redirect_pc = 64'h3000;
        step();
        check("t4_same_hs",   64'(s_hs), 64'd1);
        check("t4_same_resp", 64'(s_resp), 64'd1);
        d_redirect = 1'b0;
        step();
        check("t4_c2_inst_valid", 64'(s_inst_valid), 64'd0);
        check("t4_c2_req_valid",  64'(s_req_valid), 64'd1);
        check("t4_c2_req_addr",   s_req_addr, 64'h3000);
        step();
        check("t4_c3_inst_valid", 64'(s_inst_valid), 64'd0);
        step();
        check("t4_c4_inst_valid", 64'(s_inst_valid), 64'd1);
        check("t4_c4_inst_pc",    s_inst_pc, 64'h3000);

        // Misaligned redirect faults; no more requests; reset recovers.
        do_reset();
        for (int i = 0; i < 4; i++) step();
        d_redirect    = 1'b1;
        d_redirect_pc = 64'h3002;
        step();
        d_redirect = 1'b0;
        hs_count = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5_fault_sticky", 64'(s_fault), 64'd1);
            if (s_hs) hs_count++;
        end
        check("t5_no_requests", 64'(hs_count), 64'd0);
        do_reset();
        step();
        check("t5_reset_fault",     64'(s_fault), 64'd0);
        check("t5_reset_req_valid", 64'(s_req_valid), 64'd1);
        check("t5_reset_req_addr",  s_req_addr, 64'h2000);

        // Sequential fetch to the last word of memory.
        do_reset();
        d_redirect    = 1'b1;
        d_redirect_pc = 64'h7FFF0;
        step();
        d_redirect  = 1'b0;
        hs_count    = 0;
        max_addr    = 64'h0;
        last_pop_pc = 64'h0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_hs) begin
                hs_count++;
                if (s_req_addr > max_addr) max_addr = s_req_addr;
            end
            if (s_pop) last_pop_pc = s_inst_pc;
        end
        check("t6_req_count",  64'(hs_count), 64'd4);
        check("t6_max_addr",   max_addr, 64'h7FFFC);
        check("t6_last_word",  last_pop_pc, 64'h7FFFC);
        check("t6_fault",      64'(s_fault), 64'd1);

        // Randomized traffic against the reference model.
        lat_min = 1;
        lat_max = 3;
        do_reset();
        fault_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            d_req_ready  = ($urandom_range(3, 0) != 0);
            d_inst_ready = ($urandom_range(9, 0) < 7);
            d_redirect   = ($urandom_range(29, 0) == 0);
            case ($urandom_range(7, 0))
                0:       d_redirect_pc = (64'($urandom_range(32'h1FFFF, 32'h400)) << 2) | 64'h2;
                1:       d_redirect_pc = MEM_SIZE + 64'(4 * $urandom_range(3, 0));
                2:       d_redirect_pc = LAST - 64'(4 * $urandom_range(6, 0));
                default: d_redirect_pc = 64'($urandom_range(32'h1FFFF, 32'h400)) << 2;
            endcase
            if (m_fault) fault_cycles++;
            if (fault_cycles > 15) begin
                fault_cycles = 0;
                do_reset();
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
